// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin front end that turns simple read/write requests
// into the sync RAM's two-word command sequence. Define RAM_ARB_TIMEOUT_EN to bound WAIT_RD.
module ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] wdata0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [ADDR_SIZE-1:0] wdata1,
  output logic                 ack1,
  output logic [ADDR_SIZE-1:0] rdata,
  output logic                 err,
  output logic                 busy,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT_RD, S_DONE} state_e;

  state_e               state_q;
  logic                 owner_q, we_q, prio_q, busy_q;
  logic                 ack0_q, ack1_q, ram_rx_valid_q;
  logic [ADDR_SIZE-1:0] addr_q, wdata_q, rdata_q;
  logic [ADDR_SIZE+1:0] ram_din_q;

  logic                 grant_d, we_d;
  logic [ADDR_SIZE-1:0] addr_d, wdata_d;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`endif

  // prio_q names the requester that wins the next tie; it moves to the other side on every grant.
  always_comb begin
    // NOTE: every always_comb output gets a value before any condition, so no latch is inferred.
    grant_d = req1;
    if (req0 && req1) grant_d = prio_q;
    we_d    = grant_d ? we1    : we0;
    addr_d  = grant_d ? addr1  : addr0;
    wdata_d = grant_d ? wdata1 : wdata0;
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      owner_q        <= 1'b0;
      we_q           <= 1'b0;
      prio_q         <= 1'b0;
      busy_q         <= 1'b0;
      ack0_q         <= 1'b0;
      ack1_q         <= 1'b0;
      ram_rx_valid_q <= 1'b0;
      ram_din_q      <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_q          <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      ack0_q         <= 1'b0;
      ack1_q         <= 1'b0;
      ram_rx_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            owner_q        <= grant_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            prio_q         <= ~grant_d;
            busy_q         <= 1'b1;
            ram_rx_valid_q <= 1'b1;
            ram_din_q      <= {~we_d, 1'b0, addr_d};
            state_q        <= S_ADDR;
          end
        end
        S_ADDR: begin
          ram_rx_valid_q <= 1'b1;
          ram_din_q      <= {~we_q, 1'b1, (we_q ? wdata_q : {ADDR_SIZE{1'b0}})};
          state_q        <= S_DATA;
        end
        S_DATA: begin
          if (we_q) begin
            ack0_q  <= ~owner_q;
            ack1_q  <= owner_q;
            state_q <= S_DONE;
          end else begin
`ifdef RAM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
            state_q <= S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          if (ram_tx_valid) begin
            rdata_q <= ram_dout;
            ack0_q  <= ~owner_q;
            ack1_q  <= owner_q;
            state_q <= S_DONE;
          end
`ifdef RAM_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            ack0_q  <= ~owner_q;
            ack1_q  <= owner_q;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          busy_q  <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign rdata        = rdata_q;
  assign busy         = busy_q;
  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;
`ifdef RAM_ARB_TIMEOUT_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: requester drivers push expected responses, a monitor
// pops them on every ack and compares command words, read data, err and latency.
module tb_ram_arbiter;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       ack0, ack1, err, busy, ram_rx_valid, ram_tx_valid;
  logic [7:0] rdata, ram_dout;
  logic [9:0] ram_din;

  ram_arbiter #(.ADDR_SIZE(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .err(err), .busy(busy),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] cmd_a;
    logic [9:0] cmd_d;
    logic       is_wr;
    logic       tmo;
    logic [7:0] rdata;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         ack_order[$];
  logic [7:0] model_mem [256] = '{default: 8'h00};
  logic [7:0] model_prev_rdata = 8'h00;
  int         model_last = -1;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM model: two-word command parser with optional read delay
  logic [7:0] ram_mem [256] = '{default: 8'h00};
  logic       have_addr, pending;
  logic [9:0] ram_a;
  logic [7:0] rd_addr;
  int         ram_wait, next_delay, ram_last_delay;
  bit         ram_mute = 1'b0;
  bit         ram_rand_delay = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_tx_valid   <= 1'b0;
      ram_dout       <= 8'h00;
      have_addr      <= 1'b0;
      pending        <= 1'b0;
      ram_a          <= 10'h000;
      rd_addr        <= 8'h00;
      ram_wait       <= 0;
      next_delay     <= 0;
      ram_last_delay <= 0;
    end else begin
      ram_tx_valid <= 1'b0;
      next_delay   <= ram_rand_delay ? int'($urandom_range(3, 0)) : 0;
      if (pending) begin
        if (ram_wait == 0) begin
          ram_tx_valid <= 1'b1;
          ram_dout     <= ram_mem[rd_addr];
          pending      <= 1'b0;
        end else begin
          ram_wait <= ram_wait - 1;
        end
      end
      if (ram_rx_valid) begin
        if (!have_addr) begin
          ram_a     <= ram_din;
          have_addr <= 1'b1;
        end else begin
          have_addr <= 1'b0;
          if (ram_din[9:8] == 2'b01) begin
            ram_mem[ram_a[7:0]] <= ram_din[7:0];
          end else if (ram_din[9:8] == 2'b11 && !ram_mute) begin
            ram_last_delay <= next_delay;
            if (next_delay == 0) begin
              ram_tx_valid <= 1'b1;
              ram_dout     <= ram_mem[ram_a[7:0]];
            end else begin
              pending  <= 1'b1;
              ram_wait <= next_delay - 1;
              rd_addr  <= ram_a[7:0];
            end
          end
        end
      end
    end
  end

  // ---------------- reference model
  function automatic void push_exp(input int r, input bit we, input logic [7:0] a,
                                   input logic [7:0] d, input bit tmo);
    exp_t e;
    e.is_wr = we;
    e.tmo   = tmo;
    e.cmd_a = we ? {2'b00, a} : {2'b10, a};
    e.cmd_d = we ? {2'b01, d} : 10'h300;
    e.rdata = tmo ? model_prev_rdata : model_mem[a];
    if (we) model_mem[a] = d;
    else if (!tmo) model_prev_rdata = model_mem[a];
    if (r == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  // Winner of a tie: whoever was not served last; requester 0 after reset.
  function automatic int tie_winner();
    return (model_last == 0) ? 1 : 0;
  endfunction

  // ---------------- monitor
  int         words = 0;
  int         lat = 0;
  logic [9:0] cap_a = 10'h000;
  logic [9:0] cap_d = 10'h000;

  initial begin : monitor
    exp_t e;
    int   r, exp_lat;
    bit   has;
    forever begin
      @(negedge clk);
      if (rst) begin
        words = 0;
        lat   = 0;
      end else begin
        if (lat > 0) lat++;
        if (ram_rx_valid) begin
          check("strobe_while_busy", busy, 1);
          check("strobe_not_in_ack", ack0 | ack1, 0);
          check("strobes_per_txn", (words < 2), 1);
          if (words == 0) begin
            cap_a = ram_din;
            lat   = 1;
          end else if (words == 1) begin
            cap_d = ram_din;
          end
          words++;
        end
        if (ack0 || ack1) begin
          check("ack_exclusive", ack0 & ack1, 0);
          r   = ack1 ? 1 : 0;
          has = (r == 1) ? (q1.size() != 0) : (q0.size() != 0);
          check((r == 1) ? "ack1_expected" : "ack0_expected", has, 1);
          if (has) begin
            e = (r == 1) ? q1.pop_front() : q0.pop_front();
            check("cmd_addr_word", cap_a, e.cmd_a);
            check("cmd_data_word", cap_d, e.cmd_d);
            check("busy_in_ack", busy, 1);
            check("err", err, e.tmo);
            if (!e.is_wr) check("rdata", rdata, e.rdata);
            exp_lat = e.is_wr ? 3 : (e.tmo ? TMO + 3 : 4 + ram_last_delay);
            check("latency", lat, exp_lat);
          end
          ack_order.push_back(r);
          words = 0;
          lat   = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic run_txn(input int r, input bit we, input logic [7:0] a,
                         input logic [7:0] d, input bit tmo = 1'b0);
    bit got = 1'b0;
    push_exp(r, we, a, d, tmo);
    @(negedge clk);
    if (r == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    for (int cyc = 0; cyc < 200 && !got; cyc++) begin
      @(negedge clk);
      got = (r == 0) ? ack0 : ack1;
    end
    check("ack_within_budget", got, 1);
    if (r == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic rand_traffic(input int r, input int n);
    bit         we;
    logic [7:0] a, d;
    for (int i = 0; i < n; i++) begin
      we   = 1'($urandom_range(1, 0));
      a    = 8'($urandom_range(127, 0));
      a[7] = (r == 1);
      d    = 8'($urandom);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      run_txn(r, we, a, d);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_valid", ram_rx_valid, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_rdata", rdata, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    model_last = -1;
  endtask

  task automatic wait_strobe();
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = ram_rx_valid;
    end
    check("strobe_seen", seen, 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence
  initial begin
    int w;
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // Write then read back, single requester
    run_txn(0, 1'b1, 8'h3C, 8'hA5);
    run_txn(0, 1'b0, 8'h3C, 8'h00);
    pulse_reset();

    // Simultaneous requests right after reset
    ack_order.delete();
    w = tie_winner();
    fork
      run_txn(0, 1'b1, 8'h10, 8'h11);
      run_txn(1, 1'b1, 8'h20, 8'h22);
    join
    check("tie_order_len", ack_order.size(), 2);
    if (ack_order.size() == 2) begin
      check("tie_first", ack_order[0], w);
      check("tie_second", ack_order[1], 1 - w);
    end
    model_last = 1 - w;
    run_txn(0, 1'b0, 8'h10, 8'h00);
    run_txn(0, 1'b0, 8'h20, 8'h00);
    model_last = 0;

    // Round-robin with both requesters hammering
    ack_order.delete();
    w = tie_winner();
    fork
      begin
        for (int i = 0; i < 3; i++) run_txn(0, 1'b1, 8'(8'h40 + i), 8'(8'h50 + i));
      end
      begin
        for (int i = 0; i < 3; i++) run_txn(1, 1'b1, 8'(8'hC0 + i), 8'(8'hD0 + i));
      end
    join
    check("rr_order_len", ack_order.size(), 6);
    for (int i = 0; i < 6 && i < ack_order.size(); i++)
      check("rr_grant", ack_order[i], (i % 2 == 0) ? w : 1 - w);

    // Randomized concurrent traffic, partitioned address halves, random RAM delay
    ram_rand_delay = 1'b1;
    fork
      rand_traffic(0, 25);
      rand_traffic(1, 25);
    join
    ram_rand_delay = 1'b0;
    repeat (3) @(negedge clk);

    // Field stability: addr0 changes during ADDR
    run_txn(0, 1'b1, 8'h3C, 8'hA5);
    fork
      run_txn(0, 1'b0, 8'h3C, 8'h00);
      begin
        wait_strobe();
        addr0 = 8'hFF;
      end
    join

    // Reset during the DATA cycle of a write
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h77; wdata0 = 8'h99;
    wait_strobe();
    @(negedge clk);
    check("abort_data_strobe", ram_rx_valid, 1);
    check("abort_data_word", ram_din, {2'b01, 8'h99});
    rst = 1'b1;
    #1 check_reset_outputs();
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_last = -1;
    run_txn(0, 1'b0, 8'h77, 8'h00);

    // RAM that never answers a read
    ram_mute = 1'b1;
`ifdef RAM_ARB_TIMEOUT_EN
    run_txn(0, 1'b0, 8'h3C, 8'h00, 1'b1);
`else
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h3C;
    repeat (40) @(negedge clk);
    check("stuck_busy", busy, 1);
    check("stuck_no_ack", ack0, 0);
    req0 = 1'b0;
    pulse_reset();
`endif
    ram_mute = 1'b0;
    repeat (3) @(negedge clk);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
